carry_eval_serial: RTL and testbench

//   Digit-serial carry-out evaluator: computes C_out of A + B + C_in for wide
//   N-bit operands, W bits per clock, over N/W cycles.

---
 rtl/carry_eval_serial.sv | 164 ++++++++++++++++
 tb/tb_carry_eval_serial.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/carry_eval_serial.sv
// carry_eval_serial
//   Digit-serial carry-out evaluator. It computes the carry out of bit N-1 of
//   A + B + C_in for wide operands. Each clock evaluates one W-bit digit, so a
//   result takes D = N/W clocks instead of one long N-bit ripple chain.
//   A start/done handshake controls it. The result stays on c_out until the
//   next accepted start.
//
//   Build option EARLY_EXIT_EN:
//     undefined - LSB-first scan with the running carry registered between
//                 digits. Latency is always D clocks.
//     defined   - MSB-first scan. The first digit that does not fully
//                 propagate decides the result. Latency is 1..D clocks.
//   c_out is identical in both builds.
//
// Ports
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   start  in  1  request, sampled only in IDLE
//   a      in  N  operand A, captured on the accepted start
//   b      in  N  operand B, captured on the accepted start
//   c_in   in  1  carry into bit 0, captured on the accepted start
//   busy   out 1  high while digits are being evaluated
//   done   out 1  one-cycle pulse when c_out is valid
//   c_out  out 1  carry out of bit N-1, held until the next accepted start
module carry_eval_serial #(
    parameter int N = 1024,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic         c_out
);

    localparam int D  = N / W;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic          r_cOut;

    logic [W-1:0]  w_aDig;
    logic [W-1:0]  w_bDig;
    logic          w_digP;
    logic          w_digG;
    logic          w_digCout;
    logic          w_finish;

    // The operand registers shift one digit per RUN cycle, so the digit under
    // evaluation always sits at a fixed end of the register.
`ifdef EARLY_EXIT_EN
    assign w_aDig = r_a[N-1 -: W];
    assign w_bDig = r_b[N-1 -: W];
    // A digit that does not fully propagate fixes the carry out on its own.
    assign w_finish = (r_cnt == LAST) || !w_digP;
`else
    assign w_aDig = r_a[W-1:0];
    assign w_bDig = r_b[W-1:0];
    assign w_finish = (r_cnt == LAST);
`endif

    // Group propagate, and group generate as the digit's own ripple carry
    // from a zero carry-in.
    always_comb begin
        logic v_c;
        v_c = 1'b0;
        for (int j = 0; j < W; j++) begin
            v_c = (w_aDig[j] & w_bDig[j]) | ((w_aDig[j] ^ w_bDig[j]) & v_c);
        end
        w_digG = v_c;
        w_digP = &(w_aDig ^ w_bDig);
    end

    // With EARLY_EXIT_EN, r_carry keeps c_in for the whole scan. It only
    // matters when every digit propagates, and then G is 0 throughout.
    assign w_digCout = w_digG | (w_digP & r_carry);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_finish) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, digit scan and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_cOut  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + CW'(1);
`ifdef EARLY_EXIT_EN
                    r_a <= r_a << W;
                    r_b <= r_b << W;
`else
                    r_a     <= r_a >> W;
                    r_b     <= r_b >> W;
                    r_carry <= w_digCout;
`endif
                    if (w_finish) begin
                        r_cOut <= w_digCout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign c_out = r_cOut;

endmodule

// File: tb/tb_carry_eval_serial.sv
// tb_carry_eval_serial
//   Directed bench for carry_eval_serial. It uses three instances:
//     small (N=8, W=4)        hand-computed vectors, held start, mid-RUN reset
//     single (N=8, W=8)       D=1 edge case
//     big (N=1024, W=64)      directed and pseudo-random vectors against
//                             (a+b+c_in)>>1024
//   Expected latencies follow the build (EARLY_EXIT_EN defined or not).
module tb_carry_eval_serial;

`ifdef EARLY_EXIT_EN
    localparam bit EarlyExit = 1'b1;
`else
    localparam bit EarlyExit = 1'b0;
`endif

    logic clk;
    logic rst_n;

    logic [7:0] sA;
    logic [7:0] sB;
    logic       sCin;
    logic [1:0] sStart;
    logic [1:0] sBusy;
    logic [1:0] sDone;
    logic [1:0] sCout;

    logic [1023:0] bA;
    logic [1023:0] bB;
    logic          bCin;
    logic          bStart;
    logic          bBusy;
    logic          bDone;
    logic          bCout;

    int vecCount;
    int missCount;

    carry_eval_serial #(.N(8), .W(4)) dutSmall (
        .clk(clk), .rst_n(rst_n), .start(sStart[0]), .a(sA), .b(sB), .c_in(sCin),
        .busy(sBusy[0]), .done(sDone[0]), .c_out(sCout[0])
    );

    carry_eval_serial #(.N(8), .W(8)) dutSingle (
        .clk(clk), .rst_n(rst_n), .start(sStart[1]), .a(sA), .b(sB), .c_in(sCin),
        .busy(sBusy[1]), .done(sDone[1]), .c_out(sCout[1])
    );

    carry_eval_serial #(.N(1024), .W(64)) dutBig (
        .clk(clk), .rst_n(rst_n), .start(bStart), .a(bA), .b(bB), .c_in(bCin),
        .busy(bBusy), .done(bDone), .c_out(bCout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the comparison and reports a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation on a small instance, checking latency, result and pulse width
    task automatic smallOp(input int sel, input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic expC, input int expLat, input string tag);
        int n;
        @(negedge clk);
        sA = av; sB = bv; sCin = cv; sStart[sel] = 1'b1;
        @(negedge clk);
        sStart[sel] = 1'b0;
        sA = ~av; sB = ~bv; sCin = ~cv;
        n = 1;
        while (!sDone[sel] && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " done"}, 32'(sDone[sel]), 32'd1);
        checkOutput({tag, " latency"}, 32'(n - 1), 32'(expLat));
        checkOutput({tag, " c_out"}, 32'(sCout[sel]), 32'(expC));
        @(negedge clk);
        checkOutput({tag, " pulse"}, {30'd0, sDone[sel], sBusy[sel]}, 32'd0);
        checkOutput({tag, " held"}, 32'(sCout[sel]), 32'(expC));
    endtask

    // Expected latency on the big instance
    function automatic int bigLat(input logic [1023:0] av, input logic [1023:0] bv);
        logic [1023:0] p;
        p = av ^ bv;
        if (!EarlyExit) return 16;
        for (int k = 15; k >= 0; k--) begin
            if (p[k*64 +: 64] != {64{1'b1}}) return 16 - k;
        end
        return 16;
    endfunction

    task automatic applyStimulus(input logic [1023:0] av, input logic [1023:0] bv,
                                 input logic cv, input string tag);
        logic [1024:0] sum;
        int n;
        int expLat;
        sum    = {1'b0, av} + {1'b0, bv} + {1024'd0, cv};
        expLat = bigLat(av, bv);
        @(negedge clk);
        bA = av; bB = bv; bCin = cv; bStart = 1'b1;
        @(negedge clk);
        bStart = 1'b0;
        bA = ~av; bB = 1024'd0; bCin = ~cv;
        n = 1;
        while (!bDone && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " done"}, 32'(bDone), 32'd1);
        checkOutput({tag, " latency"}, 32'(n - 1), 32'(expLat));
        checkOutput({tag, " c_out"}, 32'(bCout), 32'(sum[1024]));
        @(negedge clk);
        checkOutput({tag, " pulse"}, {30'd0, bDone, bBusy}, 32'd0);
    endtask

    initial begin
        logic [1023:0] ra;
        logic [1023:0] rb;
        int n;
        int doneCnt;
        int overlap;
        vecCount  = 0;
        missCount = 0;
        rst_n  = 1'b0;
        sA = 8'h00; sB = 8'h00; sCin = 1'b0; sStart = 2'b00;
        bA = '0; bB = '0; bCin = 1'b0; bStart = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset small", {29'd0, sBusy[0], sDone[0], sCout[0]}, 32'd0);
        checkOutput("reset single", {29'd0, sBusy[1], sDone[1], sCout[1]}, 32'd0);
        checkOutput("reset big", {29'd0, bBusy, bDone, bCout}, 32'd0);
        rst_n = 1'b1;

        // Hand-computed N=8, W=4 vectors
        smallOp(0, 8'hFF, 8'h01, 1'b0, 1'b1, 2, "s ff+01");
        smallOp(0, 8'h80, 8'h80, 1'b0, 1'b1, EarlyExit ? 1 : 2, "s 80+80");
        smallOp(0, 8'hFF, 8'h00, 1'b1, 1'b1, 2, "s ff+00+1");
        smallOp(0, 8'hFF, 8'h00, 1'b0, 1'b0, 2, "s ff+00+0");
        smallOp(0, 8'h0F, 8'hF0, 1'b1, 1'b1, 2, "s 0f+f0+1");
        smallOp(0, 8'h7F, 8'h01, 1'b0, 1'b0, EarlyExit ? 1 : 2, "s 7f+01");

        // D=1 instance
        smallOp(1, 8'hFF, 8'h01, 1'b0, 1'b1, 1, "d1 ff+01");
        smallOp(1, 8'h7F, 8'h01, 1'b0, 1'b0, 1, "d1 7f+01");
        smallOp(1, 8'hFF, 8'h00, 1'b1, 1'b1, 1, "d1 ff+00+1");

        // start held high: one operation per IDLE visit, operands changed mid-RUN
        @(negedge clk);
        sA = 8'h80; sB = 8'h80; sCin = 1'b1; sStart[0] = 1'b1;
        @(negedge clk);
        sA = 8'hFF; sB = 8'h00; sCin = 1'b0;
        n = 1;
        while (!sDone[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold first done", 32'(sDone[0]), 32'd1);
        checkOutput("hold first c_out", 32'(sCout[0]), 32'd1);
        doneCnt = 0;
        overlap = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (sDone[0]) begin
                doneCnt++;
                checkOutput("hold later c_out", 32'(sCout[0]), 32'd0);
            end
            if (sDone[0] && sBusy[0]) overlap++;
        end
        checkOutput("hold done count", 32'(doneCnt), 32'd2);
        checkOutput("hold busy/done overlap", 32'(overlap), 32'd0);
        sStart[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-RUN
        smallOp(0, 8'h80, 8'h80, 1'b0, 1'b1, EarlyExit ? 1 : 2, "s pre-reset");
        @(negedge clk);
        sA = 8'hFF; sB = 8'h01; sCin = 1'b0; sStart[0] = 1'b1;
        @(negedge clk);
        sStart[0] = 1'b0;
        checkOutput("rst busy before", 32'(sBusy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst outputs", {29'd0, sBusy[0], sDone[0], sCout[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sDone[0]) doneCnt++;
        end
        checkOutput("rst no done", 32'(doneCnt), 32'd0);
        smallOp(0, 8'hFF, 8'h01, 1'b0, 1'b1, 2, "s post-reset");

        // Big instance: directed boundaries
        applyStimulus({1024{1'b1}}, 1024'd0, 1'b1, "b ones+0+1");
        applyStimulus({1024{1'b1}}, 1024'd0, 1'b0, "b ones+0+0");
        applyStimulus({1024{1'b1}}, 1024'd1, 1'b0, "b ones+1");
        applyStimulus({1'b1, 1023'd0}, {1'b1, 1023'd0}, 1'b0, "b msb+msb");
        applyStimulus(1024'd0, 1024'd0, 1'b1, "b zero");

        // Big instance: pseudo-random, biased toward long propagate chains
        for (int i = 0; i < 200; i++) begin
            for (int w = 0; w < 32; w++) begin
                ra[w*32 +: 32] = $urandom;
                rb[w*32 +: 32] = $urandom;
            end
            case (i % 4)
                1: rb = ~ra;
                2: begin
                    rb = ~ra;
                    rb[$urandom_range(1023, 0)] ^= 1'b1;
                end
                3: begin
                    rb = ~ra;
                    rb[$urandom_range(1023, 960)] ^= 1'b1;
                end
                default: ;
            endcase
            applyStimulus(ra, rb, 1'($urandom_range(1, 0)), $sformatf("b rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
